// File: rtl/pwm_breathe_ctrl.sv
// Purpose: breathing-envelope sequencer for one PWM channel (ramp up, hold high, ramp down, hold low).
// Latency: start accepted on a clock edge -> busy and the first period begin the next cycle; duty changes only at period boundaries.
// Backpressure: none; stop is graceful (the running period completes, then IDLE); reset aborts at once.
module pwm_breathe_ctrl #(
    parameter int PERIOD   = 100,
    parameter int DUTY_W   = 8,
    parameter int MAX_DUTY = 100,
    parameter int DUTY_INC = 10,
    parameter int CFG_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              repeat_en,
    input  logic [CFG_W-1:0]  step_cfg,
    input  logic [CFG_W-1:0]  hold_cfg,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty_out,
    output logic              period_end,
    output logic              cycle_done,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_HOLD_HIGH,
        S_RAMP_DOWN,
        S_HOLD_LOW
    } state_t;

    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W:0]   INC_X    = (DUTY_W + 1)'(DUTY_INC);
    localparam logic [DUTY_W:0]   MAX_X    = (DUTY_W + 1)'(MAX_DUTY);

    state_t             state, state_n;
    logic [DUTY_W-1:0]  cnt, cnt_n;
    logic [DUTY_W-1:0]  duty, duty_n;
    logic [CFG_W-1:0]   step_cnt, step_cnt_n;
    logic [CFG_W-1:0]   hold_cnt, hold_cnt_n;
    logic               stop_pend, stop_pend_n;
    logic [CFG_W-1:0]   step_q, step_q_n;
    logic [CFG_W-1:0]   hold_q, hold_q_n;
    logic               rep_q, rep_q_n;

    // Duty arithmetic carries one extra bit so the ramp saturates instead of wrapping.
    logic [DUTY_W:0]    duty_x;
    logic [DUTY_W:0]    up_sum;
    logic [DUTY_W-1:0]  duty_up;
    logic [DUTY_W-1:0]  duty_dn;

    // A configured count of 0 behaves like 1 so the envelope always advances.
    logic [CFG_W-1:0]   eff_step;
    logic [CFG_W-1:0]   eff_hold;
    logic [CFG_W-1:0]   step_nxt;
    logic [CFG_W-1:0]   hold_nxt;
    logic               step_hit;
    logic               hold_hit;
    logic               stop_req;

    assign duty_x  = {1'b0, duty};
    assign up_sum  = duty_x + INC_X;
    assign duty_up = (up_sum >= MAX_X) ? DUTY_MAX : up_sum[DUTY_W-1:0];
    assign duty_dn = (duty_x < INC_X) ? '0 : (duty - INC_X[DUTY_W-1:0]);

    assign eff_step = (step_q == '0) ? CFG_W'(1) : step_q;
    assign eff_hold = (hold_q == '0) ? CFG_W'(1) : hold_q;
    assign step_nxt = step_cnt + CFG_W'(1);
    assign hold_nxt = hold_cnt + CFG_W'(1);
    assign step_hit = (step_nxt == eff_step);
    assign hold_hit = (hold_nxt == eff_hold);

    // Outputs are decoded straight from registered state, so they are glitch-free per period.
    assign busy       = (state != S_IDLE);
    assign pwm_out    = busy && (cnt < duty);
    assign period_end = busy && (cnt == CNT_LAST);
    assign duty_out   = duty;
    // A stop seen in the boundary cycle itself is honoured at that boundary.
    assign stop_req   = stop_pend || stop;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            duty      <= '0;
            step_cnt  <= '0;
            hold_cnt  <= '0;
            stop_pend <= 1'b0;
            step_q    <= '0;
            hold_q    <= '0;
            rep_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            duty      <= duty_n;
            step_cnt  <= step_cnt_n;
            hold_cnt  <= hold_cnt_n;
            stop_pend <= stop_pend_n;
            step_q    <= step_q_n;
            hold_q    <= hold_q_n;
            rep_q     <= rep_q_n;
        end
    end

    // Next-state, counters and the cycle_done pulse; everything but start moves only at period_end.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        duty_n      = duty;
        step_cnt_n  = step_cnt;
        hold_cnt_n  = hold_cnt;
        stop_pend_n = stop_pend;
        step_q_n    = step_q;
        hold_q_n    = hold_q;
        rep_q_n     = rep_q;
        cycle_done  = 1'b0;

        if (state == S_IDLE) begin
            cnt_n       = '0;
            duty_n      = '0;
            stop_pend_n = 1'b0;
            // Stop wins over a simultaneous start.
            if (start && !stop) begin
                state_n    = S_RAMP_UP;
                step_cnt_n = '0;
                hold_cnt_n = '0;
                step_q_n   = step_cfg;
                hold_q_n   = hold_cfg;
                rep_q_n    = repeat_en;
            end
        end else begin
            cnt_n = period_end ? '0 : (cnt + DUTY_W'(1));
            if (stop) begin
                stop_pend_n = 1'b1;
            end
            if (period_end) begin
                case (state)
                    S_RAMP_UP: begin
                        if (step_hit) begin
                            step_cnt_n = '0;
                            duty_n     = duty_up;
                            if (duty_up == DUTY_MAX) begin
                                state_n    = S_HOLD_HIGH;
                                hold_cnt_n = '0;
                            end
                        end else begin
                            step_cnt_n = step_nxt;
                        end
                    end
                    S_HOLD_HIGH: begin
                        if (hold_hit) begin
                            hold_cnt_n = '0;
                            step_cnt_n = '0;
                            state_n    = S_RAMP_DOWN;
                        end else begin
                            hold_cnt_n = hold_nxt;
                        end
                    end
                    S_RAMP_DOWN: begin
                        if (step_hit) begin
                            step_cnt_n = '0;
                            duty_n     = duty_dn;
                            if (duty_dn == '0) begin
                                state_n    = S_HOLD_LOW;
                                hold_cnt_n = '0;
                            end
                        end else begin
                            step_cnt_n = step_nxt;
                        end
                    end
                    S_HOLD_LOW: begin
                        if (hold_hit) begin
                            // The envelope did complete here, so the pulse is shown even if a stop is pending.
                            cycle_done = 1'b1;
                            hold_cnt_n = '0;
                            step_cnt_n = '0;
                            duty_n     = '0;
                            state_n    = rep_q ? S_RAMP_UP : S_IDLE;
                        end else begin
                            hold_cnt_n = hold_nxt;
                        end
                    end
                    default: begin
                        state_n = S_IDLE;
                        duty_n  = '0;
                    end
                endcase
                // A pending stop ends the run at this boundary.
                if (stop_req) begin
                    state_n     = S_IDLE;
                    duty_n      = '0;
                    stop_pend_n = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_breathe_ctrl.sv
// Purpose: self-checking bench for pwm_breathe_ctrl; per-period records checked against a scoreboard queue.
// Latency: expected records are queued by stimulus and popped by a monitor at each period_end.
// Backpressure: none; every wait is bounded and a watchdog ends a stuck run.
module tb_pwm_breathe_ctrl;

    typedef struct packed {
        logic [7:0] duty;
        logic [7:0] highs;
        logic       done;
    } rec_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: PERIOD=10, MAX_DUTY=10, DUTY_INC=5.
    logic       rst_n, start, stop, repeat_en;
    logic [3:0] step_cfg, hold_cfg;
    logic       pwm0, pe0, cd0, busy0;
    logic [7:0] duty0;

    // Instance 1: PERIOD=10, MAX_DUTY=10, DUTY_INC=4 (clamping case).
    logic       rst_n1, start1, stop1, repeat_en1;
    logic [3:0] step_cfg1, hold_cfg1;
    logic       pwm1, pe1, cd1, busy1;
    logic [7:0] duty1;

    int   errors = 0;
    int   checks = 0;
    rec_t q0[$];
    rec_t q1[$];

    pwm_breathe_ctrl #(.PERIOD(10), .DUTY_W(8), .MAX_DUTY(10), .DUTY_INC(5), .CFG_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .repeat_en(repeat_en),
        .step_cfg(step_cfg), .hold_cfg(hold_cfg), .pwm_out(pwm0), .duty_out(duty0),
        .period_end(pe0), .cycle_done(cd0), .busy(busy0)
    );

    pwm_breathe_ctrl #(.PERIOD(10), .DUTY_W(8), .MAX_DUTY(10), .DUTY_INC(4), .CFG_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n1), .start(start1), .stop(stop1), .repeat_en(repeat_en1),
        .step_cfg(step_cfg1), .hold_cfg(hold_cfg1), .pwm_out(pwm1), .duty_out(duty1),
        .period_end(pe1), .cycle_done(cd1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int which, input int d, input int h, input bit dn);
        rec_t r;
        r.duty  = 8'(d);
        r.highs = 8'(h);
        r.done  = dn;
        if (which == 0) q0.push_back(r);
        else            q1.push_back(r);
    endtask

    // Standard envelope for instance 0 with step=1, hold=1: 0,5,10,10,5,0.
    task automatic push_std(input bit done_last);
        push(0, 0, 0, 1'b0);
        push(0, 5, 5, 1'b0);
        push(0, 10, 10, 1'b0);
        push(0, 10, 10, 1'b0);
        push(0, 5, 5, 1'b0);
        push(0, 0, 0, done_last);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pulse0();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Counts falling edges until cycle_done is seen; -1 if the bound expires.
    task automatic wait_done(input int which, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((which == 0) ? cd0 : cd1) begin
                n = i;
                break;
            end
        end
    endtask

    // Monitor for instance 0: one record per completed period.
    initial begin
        logic [7:0] hi;
        rec_t got, e;
        hi = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hi = '0;
            end else begin
                if (pwm0) hi = hi + 8'd1;
                if (cd0 && !pe0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon0_done_off_boundary: got cycle_done=1, expected 0");
                end
                if (pe0) begin
                    got.duty  = duty0;
                    got.highs = hi;
                    got.done  = cd0;
                    checks++;
                    if (q0.size() == 0) begin
                        errors++;
                        $display("FAIL mon0_unexpected_period: got duty=%0d highs=%0d done=%0d, expected no period", got.duty, got.highs, got.done);
                    end else begin
                        e = q0.pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL mon0_period: got duty=%0d highs=%0d done=%0d, expected duty=%0d highs=%0d done=%0d",
                                     got.duty, got.highs, got.done, e.duty, e.highs, e.done);
                        end
                    end
                    hi = '0;
                end
            end
        end
    end

    // Monitor for instance 1.
    initial begin
        logic [7:0] hi;
        rec_t got, e;
        hi = '0;
        forever begin
            @(negedge clk);
            if (!rst_n1) begin
                hi = '0;
            end else begin
                if (pwm1) hi = hi + 8'd1;
                if (pe1) begin
                    got.duty  = duty1;
                    got.highs = hi;
                    got.done  = cd1;
                    checks++;
                    if (q1.size() == 0) begin
                        errors++;
                        $display("FAIL mon1_unexpected_period: got duty=%0d highs=%0d done=%0d, expected no period", got.duty, got.highs, got.done);
                    end else begin
                        e = q1.pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL mon1_period: got duty=%0d highs=%0d done=%0d, expected duty=%0d highs=%0d done=%0d",
                                     got.duty, got.highs, got.done, e.duty, e.highs, e.done);
                        end
                    end
                    hi = '0;
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b1; stop = 1'b0; repeat_en = 1'b0;
        step_cfg = 4'd1; hold_cfg = 4'd1;
        rst_n1 = 1'b0; start1 = 1'b0; stop1 = 1'b0; repeat_en1 = 1'b0;
        step_cfg1 = 4'd1; hold_cfg1 = 4'd1;

        // Reset held with start asserted.
        tick(3);
        @(negedge clk);
        chk("rst_pwm", pwm0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_duty", duty0, 0);
        chk("rst_period_end", pe0, 0);
        chk("rst_cycle_done", cd0, 0);
        tick(1);
        rst_n = 1'b1; rst_n1 = 1'b1; start = 1'b0;
        tick(2);

        // Single envelope, repeat off.
        push_std(1'b1);
        start_pulse0();
        @(negedge clk);
        chk("busy_after_start", busy0, 1);
        wait_done(0, 200, n);
        chk("single_done_cycle", n + 1, 60);
        @(negedge clk);
        chk("single_busy_drop", busy0, 0);

        // Repeat loop, then stop during the third envelope's first period.
        tick(2);
        repeat_en = 1'b1;
        push_std(1'b1);
        push_std(1'b1);
        push(0, 0, 0, 1'b0);
        start_pulse0();
        wait_done(0, 200, n);
        chk("repeat_done1_cycle", n, 60);
        wait_done(0, 200, n);
        chk("repeat_done2_interval", n, 60);
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0; repeat_en = 1'b0;
        tick(9);
        @(negedge clk);
        chk("repeat_stop_busy", busy0, 0);
        chk("repeat_stop_duty", duty0, 0);

        // step=3, hold=2; config changes mid-envelope must be ignored.
        tick(2);
        step_cfg = 4'd3; hold_cfg = 4'd2;
        push(0, 0, 0, 1'b0); push(0, 0, 0, 1'b0); push(0, 0, 0, 1'b0);
        push(0, 5, 5, 1'b0); push(0, 5, 5, 1'b0); push(0, 5, 5, 1'b0);
        push(0, 10, 10, 1'b0); push(0, 10, 10, 1'b0);
        push(0, 10, 10, 1'b0); push(0, 10, 10, 1'b0); push(0, 10, 10, 1'b0);
        push(0, 5, 5, 1'b0); push(0, 5, 5, 1'b0); push(0, 5, 5, 1'b0);
        push(0, 0, 0, 1'b0); push(0, 0, 0, 1'b1);
        start_pulse0();
        repeat (5) @(negedge clk);
        step_cfg = 4'd1; hold_cfg = 4'd1; repeat_en = 1'b1;
        wait_done(0, 400, n);
        chk("slow_done_cycle", n + 5, 160);
        @(negedge clk);
        chk("slow_busy_drop", busy0, 0);

        // step_cfg=0 and hold_cfg=0 behave as 1.
        tick(2);
        repeat_en = 1'b0; step_cfg = 4'd0; hold_cfg = 4'd0;
        push_std(1'b1);
        start_pulse0();
        wait_done(0, 200, n);
        chk("zero_cfg_done_cycle", n, 60);
        @(negedge clk);
        chk("zero_cfg_busy_drop", busy0, 0);

        // Stop at cnt=3 while duty=5: period completes, no cycle_done.
        tick(2);
        step_cfg = 4'd1; hold_cfg = 4'd1;
        push(0, 0, 0, 1'b0);
        push(0, 5, 5, 1'b0);
        start_pulse0();
        tick(13);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(6);
        @(negedge clk);
        chk("stop_busy", busy0, 0);
        chk("stop_duty", duty0, 0);

        // Start and stop together in IDLE.
        tick(1);
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("start_stop_idle_busy", busy0, 0);
        chk("start_stop_idle_pwm", pwm0, 0);

        // Reset in the middle of RAMP_DOWN.
        tick(2);
        push(0, 0, 0, 1'b0);
        push(0, 5, 5, 1'b0);
        push(0, 10, 10, 1'b0);
        start_pulse0();
        tick(32);
        @(negedge clk);
        chk("pre_reset_pwm", pwm0, 1);
        chk("pre_reset_duty", duty0, 10);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        @(negedge clk);
        chk("midrst_pwm", pwm0, 0);
        chk("midrst_duty", duty0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_period_end", pe0, 0);
        tick(1);
        rst_n = 1'b1;

        // Clamping on instance 1: 0,4,8,10 up, 10 hold, 6,2,0 down, 0 hold.
        tick(2);
        push(1, 0, 0, 1'b0); push(1, 4, 4, 1'b0); push(1, 8, 8, 1'b0);
        push(1, 10, 10, 1'b0); push(1, 10, 10, 1'b0);
        push(1, 6, 6, 1'b0); push(1, 2, 2, 1'b0); push(1, 0, 0, 1'b1);
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        wait_done(1, 200, n);
        chk("clamp_done_cycle", n, 80);
        @(negedge clk);
        chk("clamp_busy_drop", busy1, 0);

        tick(3);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
